// File: rtl/uart_rx.sv
// 8-N-1 UART receiver with mid-bit sampling, stop-bit check and a valid/ready holding register.
// Define UART_RX_PARITY_EN to receive 8-E-1 frames and drive parity_err_o.
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       rx_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       frame_err_o,
    output logic       parity_err_o,
    output logic       overrun_o,
    output logic       busy_o
);

    localparam int unsigned CW   = $clog2(CLKS_PER_BIT);
    localparam int unsigned HALF = CLKS_PER_BIT / 2;
    localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t        state, state_n;
    logic          rx_m, rx_s, rx_q;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    bit_idx, bit_idx_n;
    logic [7:0]    shift, shift_n;
    logic [7:0]    data_n;
    logic          valid_n, frame_err_n, overrun_n, busy_n;
    logic          done;
`ifdef UART_RX_PARITY_EN
    logic          perr, perr_n;
    logic          parity_err_n;
`endif

    // State, synchronizer and output registers
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state       <= IDLE;
            rx_m        <= 1'b1;
            rx_s        <= 1'b1;
            rx_q        <= 1'b1;
            cnt         <= '0;
            bit_idx     <= '0;
            shift       <= '0;
            data_o      <= '0;
            valid_o     <= 1'b0;
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;
            busy_o      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr         <= 1'b0;
            parity_err_o <= 1'b0;
`endif
        end else begin
            state       <= state_n;
            rx_m        <= rx_i;
            rx_s        <= rx_m;
            rx_q        <= rx_s;
            cnt         <= cnt_n;
            bit_idx     <= bit_idx_n;
            shift       <= shift_n;
            data_o      <= data_n;
            valid_o     <= valid_n;
            frame_err_o <= frame_err_n;
            overrun_o   <= overrun_n;
            busy_o      <= busy_n;
`ifdef UART_RX_PARITY_EN
            perr         <= perr_n;
            parity_err_o <= parity_err_n;
`endif
        end
    end

`ifndef UART_RX_PARITY_EN
    assign parity_err_o = 1'b0;
`endif

    // Next-state, bit timing and holding-register update
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        bit_idx_n   = bit_idx;
        shift_n     = shift;
        data_n      = data_o;
        valid_n     = valid_o;
        frame_err_n = frame_err_o;
        overrun_n   = 1'b0;
        done        = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_n       = perr;
        parity_err_n = parity_err_o;
`endif

        if (valid_o && ready_i) begin
            valid_n = 1'b0;
        end

        case (state)
            IDLE: begin
                if (rx_q && !rx_s) begin
                    state_n = START;
                    cnt_n   = '0;
                end
            end
            START: begin
                if (cnt == CNT_HALF) begin
                    if (rx_s) begin
                        state_n = IDLE;
                    end else begin
                        state_n   = DATA;
                        cnt_n     = '0;
                        bit_idx_n = '0;
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            DATA: begin
                if (cnt == CNT_LAST) begin
                    shift_n   = {rx_s, shift[7:1]};
                    cnt_n     = '0;
                    bit_idx_n = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt == CNT_LAST) begin
                    perr_n  = rx_s ^ (^shift);
                    cnt_n   = '0;
                    state_n = STOP;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
`endif
            STOP: begin
                if (cnt == CNT_LAST) begin
                    state_n = IDLE;
                    done    = 1'b1;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: state_n = IDLE;
        endcase

        // A completed byte is dropped only if the held byte is not being taken this cycle
        if (done) begin
            if (!valid_o || ready_i) begin
                data_n      = shift;
                frame_err_n = !rx_s;
                valid_n     = 1'b1;
`ifdef UART_RX_PARITY_EN
                parity_err_n = perr;
`endif
            end else begin
                overrun_n = 1'b1;
            end
        end

        busy_n = (state_n != IDLE);
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx: ideal-timing frames driven on rx_i, outputs checked against hand values.
module tb_uart_rx;

    localparam int unsigned CPB  = 16;
    localparam int unsigned HALF = CPB / 2;

    logic       clk_i = 1'b0;
    logic       reset_i;
    logic       rx_i;
    logic [7:0] data_o;
    logic       valid_o;
    logic       ready_i;
    logic       frame_err_o;
    logic       parity_err_o;
    logic       overrun_o;
    logic       busy_o;

    int n_vec = 0;
    int n_err = 0;
    int n_ovr = 0;
    int n_vrise = 0;
    logic v_prev = 1'b0;
`ifdef UART_RX_PARITY_EN
    logic par_flip = 1'b0;
`endif

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .rx_i         (rx_i),
        .data_o       (data_o),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .frame_err_o  (frame_err_o),
        .parity_err_o (parity_err_o),
        .overrun_o    (overrun_o),
        .busy_o       (busy_o)
    );

    always #5 clk_i = ~clk_i;

    // Event counters sampled away from the active edge
    always @(negedge clk_i) begin
        if (overrun_o) n_ovr <= n_ovr + 1;
        if (valid_o && !v_prev) n_vrise <= n_vrise + 1;
        v_prev <= valid_o;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic send_bit(input logic b);
        rx_i = b;
        repeat (CPB) @(posedge clk_i);
        #1;
    endtask

    // Whole frame; rdy_done raises ready_i for exactly the stop-sample cycle
    task automatic send_frame(input logic [7:0] d, input logic stop, input logic rdy_done);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit((^d) ^ par_flip);
`endif
        rx_i = stop;
        if (rdy_done) begin
            repeat (10) @(posedge clk_i);
            #1 ready_i = 1'b1;
            @(posedge clk_i);
            #1 ready_i = 1'b0;
            repeat (5) @(posedge clk_i);
            #1;
        end else begin
            repeat (CPB) @(posedge clk_i);
            #1;
        end
        rx_i = 1'b1;
    endtask

    task automatic pulse_ready();
        ready_i = 1'b1;
        @(posedge clk_i);
        #1 ready_i = 1'b0;
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        rx_i    = 1'b1;
        ready_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        n_vec++;
        if ({data_o, valid_o, frame_err_o, parity_err_o, overrun_o, busy_o} !== 13'h0) begin
            n_err++;
            $display("FAIL reset_outputs: got data=%h v=%b fe=%b pe=%b ov=%b busy=%b expected all 0",
                     data_o, valid_o, frame_err_o, parity_err_o, overrun_o, busy_o);
        end
        reset_i = 1'b0;
        repeat (4) @(posedge clk_i);
        #1;
    endtask

    task automatic test_single_byte();
        send_frame(8'hA5, 1'b1, 1'b0);
        repeat (4) @(posedge clk_i);
        #1;
        n_vec++;
        if (valid_o !== 1'b1 || data_o !== 8'hA5 || frame_err_o !== 1'b0) begin
            n_err++;
            $display("FAIL single_byte: got v=%b data=%h fe=%b expected v=1 data=a5 fe=0",
                     valid_o, data_o, frame_err_o);
        end
        n_vec++;
        if (busy_o !== 1'b0) begin
            n_err++;
            $display("FAIL single_busy_idle: got %b expected 0", busy_o);
        end
        pulse_ready();
        n_vec++;
        if (valid_o !== 1'b0 || data_o !== 8'hA5) begin
            n_err++;
            $display("FAIL single_accept: got v=%b data=%h expected v=0 data=a5", valid_o, data_o);
        end
    endtask

    task automatic test_glitch();
        int  vr0;
        bit  fell;
        vr0  = n_vrise;
        fell = 1'b0;
        rx_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1 rx_i = 1'b1;
        @(posedge clk_i);
        #1;
        n_vec++;
        if (busy_o !== 1'b1) begin
            n_err++;
            $display("FAIL glitch_busy_rise: got %b expected 1", busy_o);
        end
        for (int k = 0; k < HALF + 1; k++) begin
            @(posedge clk_i);
            #1;
            if (busy_o === 1'b0) begin
                fell = 1'b1;
                break;
            end
        end
        n_vec++;
        if (!fell) begin
            n_err++;
            $display("FAIL glitch_busy_fall: got busy=%b expected 0 within %0d cycles", busy_o, HALF + 1);
        end
        repeat (2 * CPB) @(posedge clk_i);
        #1;
        n_vec++;
        if (valid_o !== 1'b0 || n_vrise != vr0) begin
            n_err++;
            $display("FAIL glitch_no_valid: got v=%b rises=%0d expected v=0 rises=0", valid_o, n_vrise - vr0);
        end
    endtask

    task automatic test_bad_stop();
        send_frame(8'h3C, 1'b0, 1'b0);
        repeat (2 * CPB) @(posedge clk_i);
        #1;
        n_vec++;
        if (valid_o !== 1'b1 || data_o !== 8'h3C || frame_err_o !== 1'b1) begin
            n_err++;
            $display("FAIL bad_stop: got v=%b data=%h fe=%b expected v=1 data=3c fe=1",
                     valid_o, data_o, frame_err_o);
        end
        pulse_ready();
        send_frame(8'h81, 1'b1, 1'b0);
        repeat (4) @(posedge clk_i);
        #1;
        n_vec++;
        if (valid_o !== 1'b1 || data_o !== 8'h81 || frame_err_o !== 1'b0) begin
            n_err++;
            $display("FAIL after_bad_stop: got v=%b data=%h fe=%b expected v=1 data=81 fe=0",
                     valid_o, data_o, frame_err_o);
        end
        pulse_ready();
    endtask

    task automatic test_back_to_back();
        int ov0;
        ov0 = n_ovr;
        send_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0);
        repeat (4) @(posedge clk_i);
        #1;
        n_vec++;
        if (n_ovr - ov0 != 1) begin
            n_err++;
            $display("FAIL overrun_pulse: got %0d pulses expected 1", n_ovr - ov0);
        end
        n_vec++;
        if (valid_o !== 1'b1 || data_o !== 8'h11) begin
            n_err++;
            $display("FAIL overrun_hold: got v=%b data=%h expected v=1 data=11", valid_o, data_o);
        end
        pulse_ready();
        ov0 = n_ovr;
        send_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b1);
        repeat (4) @(posedge clk_i);
        #1;
        n_vec++;
        if (n_ovr != ov0) begin
            n_err++;
            $display("FAIL same_cycle_no_overrun: got %0d pulses expected 0", n_ovr - ov0);
        end
        n_vec++;
        if (valid_o !== 1'b1 || data_o !== 8'h22) begin
            n_err++;
            $display("FAIL same_cycle_accept: got v=%b data=%h expected v=1 data=22", valid_o, data_o);
        end
    endtask

    // Enters with 0x22 still held so the clear on reset is visible
    task automatic test_reset_mid_frame();
        int ov0;
        ov0 = n_ovr;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        rx_i = 1'b1;
        repeat (HALF) @(posedge clk_i);
        #1;
        n_vec++;
        if (busy_o !== 1'b1) begin
            n_err++;
            $display("FAIL mid_frame_busy: got %b expected 1", busy_o);
        end
        reset_i = 1'b1;
        @(posedge clk_i);
        #1 reset_i = 1'b0;
        n_vec++;
        if ({data_o, valid_o, frame_err_o, parity_err_o, overrun_o, busy_o} !== 13'h0) begin
            n_err++;
            $display("FAIL mid_reset_outputs: got data=%h v=%b fe=%b pe=%b ov=%b busy=%b expected all 0",
                     data_o, valid_o, frame_err_o, parity_err_o, overrun_o, busy_o);
        end
        repeat (8 * CPB) @(posedge clk_i);
        #1;
        n_vec++;
        if (valid_o !== 1'b0 || busy_o !== 1'b0 || n_ovr != ov0) begin
            n_err++;
            $display("FAIL mid_reset_quiet: got v=%b busy=%b ov=%0d expected 0 0 0", valid_o, busy_o, n_ovr - ov0);
        end
        send_frame(8'h5A, 1'b1, 1'b0);
        repeat (4) @(posedge clk_i);
        #1;
        n_vec++;
        if (valid_o !== 1'b1 || data_o !== 8'h5A || frame_err_o !== 1'b0) begin
            n_err++;
            $display("FAIL after_reset_frame: got v=%b data=%h fe=%b expected v=1 data=5a fe=0",
                     valid_o, data_o, frame_err_o);
        end
        pulse_ready();
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        par_flip = 1'b0;
        send_frame(8'h07, 1'b1, 1'b0);
        repeat (4) @(posedge clk_i);
        #1;
        n_vec++;
        if (valid_o !== 1'b1 || data_o !== 8'h07 || parity_err_o !== 1'b0) begin
            n_err++;
            $display("FAIL parity_good: got v=%b data=%h pe=%b expected v=1 data=07 pe=0",
                     valid_o, data_o, parity_err_o);
        end
        pulse_ready();
        par_flip = 1'b1;
        send_frame(8'h07, 1'b1, 1'b0);
        par_flip = 1'b0;
        repeat (4) @(posedge clk_i);
        #1;
        n_vec++;
        if (valid_o !== 1'b1 || data_o !== 8'h07 || parity_err_o !== 1'b1) begin
            n_err++;
            $display("FAIL parity_bad: got v=%b data=%h pe=%b expected v=1 data=07 pe=1",
                     valid_o, data_o, parity_err_o);
        end
        pulse_ready();
    endtask
`else
    task automatic test_parity();
        send_frame(8'h07, 1'b1, 1'b0);
        repeat (4) @(posedge clk_i);
        #1;
        n_vec++;
        if (valid_o !== 1'b1 || data_o !== 8'h07 || parity_err_o !== 1'b0) begin
            n_err++;
            $display("FAIL parity_tied_off: got v=%b data=%h pe=%b expected v=1 data=07 pe=0",
                     valid_o, data_o, parity_err_o);
        end
        pulse_ready();
    endtask
`endif

    initial begin
        test_reset();
        test_single_byte();
        test_glitch();
        test_bad_stop();
        test_back_to_back();
        test_reset_mid_frame();
        test_parity();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
